// File: rtl/rv32im_fetch.sv
// rv32im_fetch: instruction fetch stage between a 1-cycle-latency instruction
//   memory and decode. Issues one sequential request per cycle, buffers returned
//   words in a 2-entry queue, and flushes everything on an execute redirect.
// Ports:
//   clk, resetn                  core clock, synchronous active-low reset
//   imem_req, imem_addr          read request / word-aligned byte address
//   imem_rdata                   word returned one cycle after a request
//   redirect_valid, redirect_pc  single-cycle PC change from execute
//   if_valid, if_pc, if_instr    instruction offered to decode
//   id_ready                     decode accepts the offered instruction
// Latency: request in cycle N is offered to decode in cycle N+2.
// Backpressure: id_ready=0 holds the head entry stable; issue stops once the
//   queue plus the in-flight request would exceed two entries.

module rv32im_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        id_ready
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Sequential fetch pointer and the single outstanding memory request.
  logic [31:0] fetch_pc;
  logic        inflight;
  logic [31:0] inflight_pc;

  // Two-entry instruction queue.
  logic [31:0] q_pc    [2];
  logic [31:0] q_instr [2];
  logic [1:0]  count;
  logic        head;
  logic        tail;

  logic        pop;
  logic        push;
  logic        issue;
  logic [2:0]  occ_after;
  logic [31:0] redirect_addr;

  assign redirect_addr = {redirect_pc[31:2], 2'b00};

  // A redirect cancels whatever decode might have taken this cycle.
  assign pop  = if_valid & id_ready & ~redirect_valid;

  // The response of the request issued last cycle lands now; it belongs to the
  // old path if a redirect is happening, so it is dropped in that case.
  assign push = inflight & ~redirect_valid;

  // Slots that will be committed after this cycle: queued entries plus the
  // response still owed by memory, minus what decode takes now. A new request
  // is only safe if its response is guaranteed a slot. pop implies count>=1,
  // so the subtraction never underflows.
  assign occ_after = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};

  always_comb begin
    imem_req  = 1'b0;
    imem_addr = fetch_pc;
    if (redirect_valid) begin
      imem_addr = redirect_addr;
    end
    if (resetn) begin
      imem_req = redirect_valid | (occ_after < 3'd2);
    end
  end

  assign issue = imem_req;

  always_comb begin
    if_valid = (count != 2'd0);
    if_pc    = 32'h0;
    if_instr = NOP_INSTR;
    if (if_valid) begin
      if_pc    = q_pc[head];
      if_instr = q_instr[head];
    end
  end

  // Fetch pointer and in-flight tracking.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= 32'h0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= imem_addr;
        // Natural 32-bit wrap: 0xFFFF_FFFC is followed by 0x0000_0000.
        fetch_pc    <= imem_addr + 32'd4;
      end
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      count <= 2'd0;
      head  <= 1'b0;
      tail  <= 1'b0;
    end else if (redirect_valid) begin
      count <= 2'd0;
      head  <= 1'b0;
      tail  <= 1'b0;
    end else begin
      if (push) begin
        tail <= ~tail;
      end
      if (pop) begin
        head <= ~head;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Queue storage.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 2; i++) begin
        q_pc[i]    <= 32'h0;
        q_instr[i] <= 32'h0;
      end
    end else if (push) begin
      q_pc[tail]    <= inflight_pc;
      q_instr[tail] <= imem_rdata;
    end
  end

endmodule
